layer_mem_bridge: RTL and testbench

//  Downstream stage of the layer controller memory port: converts the 4-phase MEM_REQ/MEM_ACK handshake
//  (MEM_REQ_OUT, MEM_WRITE, MEM_AOUT, MEM_DOUT) into single-port synchronous SRAM cycles.

---
 rtl/layer_mem_bridge.sv | 186 ++++++++++++++++++
 tb/tb_layer_mem_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mem_bridge.sv
// layer_mem_bridge: converts the layer controller's 4-phase MEM_REQ/MEM_ACK
// memory handshake into single-port synchronous SRAM cycles, one access at a time.
// Optional build macro: LC_MEM_BRIDGE_RANGE_CHK_EN rejects word addresses >= DEPTH
// with MEM_ERR instead of letting them alias into the SRAM.
`timescale 1ns/1ps
module layer_mem_bridge #(
    parameter int unsigned AW         = 30,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                     CLK,
    input  logic                     MEM_ACK_RSTn,
    input  logic                     MEM_REQ_IN,
    input  logic                     MEM_WRITE,
    input  logic [AW-1:0]            MEM_AIN,
    input  logic [DW-1:0]            MEM_DIN,
    output logic                     MEM_ACK_OUT,
    output logic [DW-1:0]            MEM_DOUT,
    output logic                     MEM_ERR,
    output logic                     SRAM_CEn,
    output logic                     SRAM_WEn,
    output logic [$clog2(DEPTH)-1:0] SRAM_A,
    output logic [DW-1:0]            SRAM_D,
    input  logic [DW-1:0]            SRAM_Q
);

    localparam int unsigned SAW = $clog2(DEPTH);
    localparam int unsigned LW  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            ack_nxt;
    logic [DW-1:0]   dout_nxt;
    logic            err_nxt;
    logic            cen_nxt;
    logic            wen_nxt;
    logic [SAW-1:0]  a_nxt;
    logic [DW-1:0]   d_nxt;
    logic [LW-1:0]   lat_cnt, lat_cnt_nxt;
    logic            wr, wr_nxt;
    logic            addr_hi;

    assign addr_hi = |MEM_AIN[AW-1:SAW];

`ifdef LC_MEM_BRIDGE_RANGE_CHK_EN
    logic            rng_err, rng_err_nxt;

    // Out-of-range flag for the accepted request
    always_ff @(posedge CLK or negedge MEM_ACK_RSTn) begin
        if (!MEM_ACK_RSTn) begin
            rng_err <= 1'b0;
        end else begin
            rng_err <= rng_err_nxt;
        end
    end
`else
    logic            unused_addr_hi;
    assign unused_addr_hi = addr_hi;
`endif

    // State and registered outputs
    always_ff @(posedge CLK or negedge MEM_ACK_RSTn) begin
        if (!MEM_ACK_RSTn) begin
            state       <= IDLE;
            MEM_ACK_OUT <= 1'b0;
            MEM_DOUT    <= '0;
            MEM_ERR     <= 1'b0;
            SRAM_CEn    <= 1'b1;
            SRAM_WEn    <= 1'b1;
            SRAM_A      <= '0;
            SRAM_D      <= '0;
            lat_cnt     <= '0;
            wr          <= 1'b0;
        end else begin
            state       <= state_nxt;
            MEM_ACK_OUT <= ack_nxt;
            MEM_DOUT    <= dout_nxt;
            MEM_ERR     <= err_nxt;
            SRAM_CEn    <= cen_nxt;
            SRAM_WEn    <= wen_nxt;
            SRAM_A      <= a_nxt;
            SRAM_D      <= d_nxt;
            lat_cnt     <= lat_cnt_nxt;
            wr          <= wr_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        ack_nxt     = MEM_ACK_OUT;
        dout_nxt    = MEM_DOUT;
        err_nxt     = MEM_ERR;
        cen_nxt     = SRAM_CEn;
        wen_nxt     = SRAM_WEn;
        a_nxt       = SRAM_A;
        d_nxt       = SRAM_D;
        lat_cnt_nxt = lat_cnt;
        wr_nxt      = wr;
`ifdef LC_MEM_BRIDGE_RANGE_CHK_EN
        rng_err_nxt = rng_err;
`endif

        unique case (state)
            IDLE: begin
                if (MEM_REQ_IN) begin
                    wr_nxt    = MEM_WRITE;
                    state_nxt = ACCESS;
`ifdef LC_MEM_BRIDGE_RANGE_CHK_EN
                    rng_err_nxt = addr_hi;
                    if (!addr_hi) begin
                        cen_nxt = 1'b0;
                        wen_nxt = ~MEM_WRITE;
                        a_nxt   = MEM_AIN[SAW-1:0];
                        d_nxt   = MEM_DIN;
                    end
`else
                    cen_nxt = 1'b0;
                    wen_nxt = ~MEM_WRITE;
                    a_nxt   = MEM_AIN[SAW-1:0];
                    d_nxt   = MEM_DIN;
`endif
                end
            end

            ACCESS: begin
                cen_nxt = 1'b1;
                wen_nxt = 1'b1;
`ifdef LC_MEM_BRIDGE_RANGE_CHK_EN
                if (rng_err) begin
                    // Rejected access: no SRAM cycle was issued, answer with an error
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = ACK;
                    if (!wr) begin
                        dout_nxt = '0;
                    end
                end else
`endif
                if (wr) begin
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end else begin
                    lat_cnt_nxt = LW'(RD_LATENCY - 1);
                    if (RD_LATENCY == 1) begin
                        dout_nxt  = SRAM_Q;
                        ack_nxt   = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end

            WAIT: begin
                lat_cnt_nxt = lat_cnt - LW'(1);
                if (lat_cnt == LW'(1)) begin
                    dout_nxt  = SRAM_Q;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end

            ACK: begin
                // Hold the response until the controller withdraws its request
                if (!MEM_REQ_IN) begin
                    ack_nxt   = 1'b0;
                    err_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_layer_mem_bridge.sv
// tb_layer_mem_bridge: scoreboard bench for layer_mem_bridge with a behavioural
// SRAM and a word-addressed reference memory; honours LC_MEM_BRIDGE_RANGE_CHK_EN.
`timescale 1ns/1ps
module tb_layer_mem_bridge;

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned SAW   = 10;
    localparam int unsigned RDL   = 3;
`ifdef LC_MEM_BRIDGE_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           MEM_ACK_RSTn;
    logic           MEM_REQ_IN;
    logic           MEM_WRITE;
    logic [AW-1:0]  MEM_AIN;
    logic [DW-1:0]  MEM_DIN;
    logic           MEM_ACK_OUT;
    logic [DW-1:0]  MEM_DOUT;
    logic           MEM_ERR;
    logic           SRAM_CEn;
    logic           SRAM_WEn;
    logic [SAW-1:0] SRAM_A;
    logic [DW-1:0]  SRAM_D;
    logic [DW-1:0]  SRAM_Q;

    layer_mem_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
        .CLK(CLK), .MEM_ACK_RSTn(MEM_ACK_RSTn), .MEM_REQ_IN(MEM_REQ_IN),
        .MEM_WRITE(MEM_WRITE), .MEM_AIN(MEM_AIN), .MEM_DIN(MEM_DIN),
        .MEM_ACK_OUT(MEM_ACK_OUT), .MEM_DOUT(MEM_DOUT), .MEM_ERR(MEM_ERR),
        .SRAM_CEn(SRAM_CEn), .SRAM_WEn(SRAM_WEn), .SRAM_A(SRAM_A),
        .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        bit            err;
        int            lat;
        int            issue;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural SRAM: write or read launched mid-cycle while CEn is low;
    // read data is presented only in the half-cycle before the RDL-th edge
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] rd_data;
    int            rd_cd = 0;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) sram[i] = '0;
        SRAM_Q  = '0;
        rd_data = '0;
    end

    always @(negedge CLK) begin
        if (!MEM_ACK_RSTn) begin
            rd_cd  <= 0;
            SRAM_Q <= $urandom();
        end else if (!SRAM_CEn && !SRAM_WEn) begin
            sram[SRAM_A] <= SRAM_D;
            SRAM_Q       <= $urandom();
        end else if (!SRAM_CEn) begin
            rd_data <= sram[SRAM_A];
            rd_cd   <= int'(RDL) - 1;
            SRAM_Q  <= (RDL == 1) ? sram[SRAM_A] : $urandom();
        end else if (rd_cd == 1) begin
            SRAM_Q <= rd_data;
            rd_cd  <= 0;
        end else begin
            if (rd_cd > 1) rd_cd <= rd_cd - 1;
            SRAM_Q <= $urandom();
        end
    end

    // Reference model: word memory, wrap-around or rejection of high addresses
    logic [DW-1:0] ref_mem [int unsigned];
    logic [DW-1:0] last_dout = '0;

    function automatic exp_t predict(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        exp_t        e;
        int unsigned key;
        e.wr   = wr;
        e.addr = addr;
        e.din  = din;
        e.err  = RCHK && (addr >= AW'(DEPTH));
        key    = int'(addr) % DEPTH;
        if (e.err) begin
            e.dout = wr ? last_dout : '0;
        end else if (wr) begin
            ref_mem[key] = din;
            e.dout = last_dout;
        end else begin
            e.dout = ref_mem.exists(key) ? ref_mem[key] : '0;
        end
        last_dout = e.dout;
        e.lat     = (wr || e.err) ? 1 : int'(RDL);
        e.issue   = 0;
        return e;
    endfunction

    // Monitor: SRAM cycle shape and acknowledge contents against the scoreboard
    bit ack_q = 1'b0;
    bit cen_q = 1'b1;
    always @(negedge CLK) begin
        if (MEM_ACK_RSTn) begin
            if (!SRAM_CEn) begin
                check("cen_expected", 64'(sb.size() != 0 && !sb[0].err), 64'd1);
                check("cen_single_cycle", 64'(cen_q), 64'd1);
                check("cen_during_ack", 64'(MEM_ACK_OUT), 64'd0);
                if (sb.size() != 0) begin
                    check("sram_addr", 64'(SRAM_A), 64'(sb[0].addr[SAW-1:0]));
                    check("sram_wen", 64'(SRAM_WEn), 64'(!sb[0].wr));
                    if (sb[0].wr) check("sram_data", 64'(SRAM_D), 64'(sb[0].din));
                end
            end
            if (MEM_ACK_OUT && !ack_q) begin
                check("ack_has_request", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_latency", 64'(cyc - e.issue), 64'(e.lat));
                    check("ack_err", 64'(MEM_ERR), 64'(e.err));
                    check(e.wr ? "dout_after_write" : "dout_read", 64'(MEM_DOUT), 64'(e.dout));
                end
            end
        end
        ack_q <= MEM_ACK_OUT;
        cen_q <= SRAM_CEn;
    end

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (MEM_ACK_OUT) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            bad++;
            total++;
            $display("FAIL ack_timeout: got=no_ack want=ack within 20 cycles (t=%0t)", $time);
            sb.delete();
        end
    endtask

    // One complete handshake; early_drop withdraws the request before the ack
    task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                          input int hold, input bit early_drop);
        exp_t e;
        bit   ok;
        @(negedge CLK);
        MEM_REQ_IN = 1'b1;
        MEM_WRITE  = wr;
        MEM_AIN    = addr;
        MEM_DIN    = din;
        e          = predict(wr, addr, din);
        e.issue    = cyc + 1;
        sb.push_back(e);
        @(negedge CLK);
        MEM_WRITE = 1'($urandom());
        MEM_AIN   = AW'($urandom());
        MEM_DIN   = $urandom();
        if (early_drop) MEM_REQ_IN = 1'b0;
        wait_ack(ok);
        if (ok) begin
            if (early_drop) begin
                @(negedge CLK);
                check("ack_pulse_early_drop", 64'(MEM_ACK_OUT), 64'd0);
            end else begin
                for (int i = 0; i < hold; i++) begin
                    @(negedge CLK);
                    check("ack_hold", 64'(MEM_ACK_OUT), 64'd1);
                    check("dout_hold", 64'(MEM_DOUT), 64'(e.dout));
                end
                MEM_REQ_IN = 1'b0;
                @(negedge CLK);
                check("ack_fall", 64'(MEM_ACK_OUT), 64'd0);
                check("err_fall", 64'(MEM_ERR), 64'd0);
            end
        end
        MEM_REQ_IN = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},  64'(MEM_ACK_OUT), 64'd0);
        check({tag, "_cen"},  64'(SRAM_CEn),    64'd1);
        check({tag, "_wen"},  64'(SRAM_WEn),    64'd1);
        check({tag, "_dout"}, 64'(MEM_DOUT),    64'd0);
        check({tag, "_err"},  64'(MEM_ERR),     64'd0);
        check({tag, "_a"},    64'(SRAM_A),      64'd0);
        check({tag, "_d"},    64'(SRAM_D),      64'd0);
    endtask

    initial begin
        MEM_ACK_RSTn = 1'b0;
        MEM_REQ_IN   = 1'b0;
        MEM_WRITE    = 1'b0;
        MEM_AIN      = '0;
        MEM_DIN      = '0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset");
        MEM_ACK_RSTn = 1'b1;
        repeat (2) @(negedge CLK);

        // Directed cases
        do_txn(1'b1, AW'(32'h10),  32'hDEADBEEF, 0, 1'b0);
        do_txn(1'b0, AW'(32'h10),  32'h0,        1, 1'b0);
        do_txn(1'b1, AW'(32'h3FF), 32'hCAFEF00D, 2, 1'b0);
        do_txn(1'b0, AW'(32'h3FF), 32'h0,        0, 1'b0);
        do_txn(1'b1, AW'(32'h400), 32'h12345678, 0, 1'b0);
        do_txn(1'b0, AW'(32'h400), 32'h0,        1, 1'b0);
        do_txn(1'b0, AW'(32'h000), 32'h0,        0, 1'b0);
        do_txn(1'b1, AW'(32'h3FF), 32'hA5A5A5A5, 0, 1'b1);
        do_txn(1'b0, AW'(32'h3FF), 32'h0,        0, 1'b1);

        // Reset while the read is waiting on SRAM latency
        @(negedge CLK);
        MEM_REQ_IN = 1'b1;
        MEM_WRITE  = 1'b0;
        MEM_AIN    = AW'(32'h10);
        begin
            exp_t e;
            e       = predict(1'b0, AW'(32'h10), '0);
            e.issue = cyc + 1;
            sb.push_back(e);
        end
        repeat (2) @(negedge CLK);
        #1;
        MEM_ACK_RSTn = 1'b0;
        #1;
        check_reset_values("reset_in_wait");
        sb.delete();
        last_dout  = '0;
        MEM_REQ_IN = 1'b0;
        @(negedge CLK);
        MEM_ACK_RSTn = 1'b1;
        @(negedge CLK);
        do_txn(1'b0, AW'(32'h10), 32'h0, 0, 1'b0);

        // Randomized traffic, addresses spanning twice the SRAM depth
        for (int n = 0; n < 80; n++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 2 * DEPTH - 1));
            if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 15));
            do_txn(1'($urandom()), a, $urandom(), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 7) == 0));
        end

        repeat (5) @(negedge CLK);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
